fma16_result_pack: RTL and testbench



---
 rtl/fma16_pkg.sv | 13 +
 rtl/fma16_pack_logic.sv | 33 +++
 rtl/fma16_result_pack.sv | 87 ++++++++
 tb/tb_fma16_result_pack.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fma16_pkg.sv
// fma16_pkg: shared binary16 field widths, special encodings and exception flag bit positions
package fma16_pkg;
  localparam int EXP_W = 5;
  localparam int FRAC_W = 10;
  localparam int BIAS = 15;
  localparam int EXP_MAX = 31;
  localparam logic [15:0] QNAN = 16'h7E00;
  localparam logic [15:0] POS_INF = 16'h7C00;
  localparam int FLG_NV = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;
endpackage

// File: rtl/fma16_pack_logic.sv
// fma16_pack_logic: combinational binary16 packing of rounded sign/exp/frac plus special tags into result and {nv,of,uf,nx} flags
module fma16_pack_logic
  import fma16_pkg::*;
#(
  parameter logic [15:0] NAN_VAL = QNAN
) (
  input  logic        in_sign,
  input  logic [6:0]  in_exp,
  input  logic [9:0]  in_frac,
  input  logic        in_inexact,
  input  logic        in_is_nan,
  input  logic        in_is_inf,
  input  logic        in_is_zero,
  input  logic        in_invalid,
  output logic [15:0] result,
  output logic [3:0]  flags
);
  logic special, ovf, unf;
  assign special = in_invalid | in_is_nan | in_is_inf | in_is_zero;
  assign ovf = $signed(in_exp) >= $signed(7'(EXP_MAX));
  assign unf = $signed(in_exp) <= $signed(7'd0);
  assign result = (in_invalid | in_is_nan) ? NAN_VAL :
                  (in_is_inf | (!in_is_zero & ovf)) ? {in_sign, POS_INF[14:0]} :
                  (in_is_zero | unf) ? {in_sign, 15'h0} :
                  {in_sign, in_exp[EXP_W-1:0], in_frac};
  always_comb begin
    flags = '0;
    flags[FLG_NV] = in_invalid;
    flags[FLG_OF] = !special & ovf;
    flags[FLG_UF] = !special & !ovf & unf;
    flags[FLG_NX] = !special & (ovf | unf | in_inexact);
  end
endmodule

// File: rtl/fma16_result_pack.sv
// fma16_result_pack: packs rounded fma16 results to binary16+flags, queues DEPTH entries behind valid/ready, accumulates sticky flags
module fma16_result_pack #(
  parameter int DEPTH = 2,
  parameter logic [15:0] QNAN = 16'h7E00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [6:0]  in_exp,
  input  logic [9:0]  in_frac,
  input  logic        in_inexact,
  input  logic        in_is_nan,
  input  logic        in_is_inf,
  input  logic        in_is_zero,
  input  logic        in_invalid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [3:0]  out_flags,
  input  logic        flags_clr,
  output logic [3:0]  sticky_flags
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  logic [15:0] res_q [DEPTH];
  logic [15:0] res_d [DEPTH];
  logic [3:0] flg_q [DEPTH];
  logic [3:0] flg_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] sticky_q, sticky_d;
  logic [15:0] pack_result;
  logic [3:0] pack_flags;
  logic push, pop;
  fma16_pack_logic #(.NAN_VAL(QNAN)) u_pack (
    .in_sign(in_sign),
    .in_exp(in_exp),
    .in_frac(in_frac),
    .in_inexact(in_inexact),
    .in_is_nan(in_is_nan),
    .in_is_inf(in_is_inf),
    .in_is_zero(in_is_zero),
    .in_invalid(in_invalid),
    .result(pack_result),
    .flags(pack_flags)
  );
  assign in_ready = cnt_q < FULL;
  assign out_valid = cnt_q != '0;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign out_result = out_valid ? res_q[rd_q] : '0;
  assign out_flags = out_valid ? flg_q[rd_q] : '0;
  assign sticky_flags = sticky_q;
  always_comb begin
    res_d = res_q;
    flg_d = flg_q;
    if (push) begin
      res_d[wr_q] = pack_result;
      flg_d[wr_q] = pack_flags;
    end
    wr_d = push ? (wr_q == LAST ? '0 : wr_q + 1'b1) : wr_q;
    rd_d = pop ? (rd_q == LAST ? '0 : rd_q + 1'b1) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    sticky_d = (flags_clr ? 4'h0 : sticky_q) | (push ? pack_flags : 4'h0);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      res_q <= '{default: '0};
      flg_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      sticky_q <= '0;
    end else begin
      res_q <= res_d;
      flg_q <= flg_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      sticky_q <= sticky_d;
    end
  end
endmodule

// File: tb/tb_fma16_result_pack.sv
// tb_fma16_result_pack: scoreboard bench with a rule-level binary16 packing model and random plus directed stimulus
module tb_fma16_result_pack;
  localparam int DEPTH = 2;
  logic clk = 0, reset = 1, in_valid = 0, in_sign = 0, in_inexact = 0;
  logic in_is_nan = 0, in_is_inf = 0, in_is_zero = 0, in_invalid = 0;
  logic [6:0] in_exp = 0;
  logic [9:0] in_frac = 0;
  logic out_ready = 0, flags_clr = 0;
  logic in_ready, out_valid;
  logic [15:0] out_result;
  logic [3:0] out_flags, sticky_flags;
  int checks = 0, errors = 0;
  logic [19:0] sb [$];
  logic [19:0] cur = 0;
  logic [3:0] sticky_m = 0;
  bit rnd_rdy = 0, started = 0;
  logic [6:0] edges [7] = '{7'd0, 7'd1, 7'd30, 7'd31, 7'd32, 7'h7F, 7'h40};

  fma16_result_pack #(.DEPTH(DEPTH), .QNAN(16'h7E00)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_frac(in_frac), .in_inexact(in_inexact),
    .in_is_nan(in_is_nan), .in_is_inf(in_is_inf), .in_is_zero(in_is_zero),
    .in_invalid(in_invalid), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .flags_clr(flags_clr),
    .sticky_flags(sticky_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] model(input logic s, input logic [6:0] e7, input logic [9:0] f,
                                        input logic nx, input logic nan, input logic inf,
                                        input logic zero, input logic inv);
    int e;
    e = int'($signed(e7));
    if (inv) return {16'h7E00, 4'b1000};
    if (nan) return {16'h7E00, 4'b0000};
    if (inf) return {s, 15'h7C00, 4'b0000};
    if (zero) return {s, 15'h0000, 4'b0000};
    if (e >= 31) return {s, 15'h7C00, 4'b0101};
    if (e <= 0) return {s, 15'h0000, 4'b0011};
    return {s, 5'(e), f, 3'b000, nx};
  endfunction

  always @(negedge clk) begin
    if (started && !reset) begin
      chk("in_ready", {19'h0, in_ready}, {19'h0, sb.size() < DEPTH});
      chk("sticky", {16'h0, sticky_flags}, {16'h0, sticky_m});
      if (sb.size() == 0) begin
        chk("empty_valid", {19'h0, out_valid}, 20'h0);
        chk("empty_head", {out_result, out_flags}, 20'h0);
      end else begin
        chk("valid", {19'h0, out_valid}, 20'h1);
        chk("head", {out_result, out_flags}, sb[0]);
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic step(output bit acc);
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk);
    if (flags_clr) sticky_m = acc ? cur[3:0] : 4'h0;
    else if (acc) sticky_m = sticky_m | cur[3:0];
    if (acc) sb.push_back(cur);
    #1;
    if (rnd_rdy) out_ready = $urandom_range(0, 1) != 0;
  endtask

  task automatic send(input logic s, input logic [6:0] e, input logic [9:0] f, input logic nx,
                      input logic nan, input logic inf, input logic zero, input logic inv,
                      input logic clr);
    bit acc = 0;
    in_sign = s; in_exp = e; in_frac = f; in_inexact = nx;
    in_is_nan = nan; in_is_inf = inf; in_is_zero = zero; in_invalid = inv;
    flags_clr = clr; in_valid = 1;
    cur = model(s, e, f, nx, nan, inf, zero, inv);
    for (int n = 0; n < 100 && !acc; n++) step(acc);
    if (!acc) chk("accept_timeout", 20'h0, 20'h1);
    in_valid = 0; flags_clr = 0;
  endtask

  task automatic norm(input logic s, input logic [6:0] e, input logic [9:0] f, input logic nx);
    send(s, e, f, nx, 0, 0, 0, 0, 0);
  endtask

  task automatic idle(input int n, input logic clr);
    bit a;
    flags_clr = clr;
    for (int i = 0; i < n; i++) step(a);
    flags_clr = 0;
  endtask

  task automatic do_reset;
    reset = 1;
    @(posedge clk);
    sb.delete();
    sticky_m = 0;
    #1 reset = 0;
  endtask

  task automatic peek(input string name, input logic [19:0] head, input logic [3:0] st);
    @(negedge clk);
    chk(name, {out_result, out_flags}, head);
    chk({name, "_sticky"}, {16'h0, sticky_flags}, {16'h0, st});
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    do_reset();
    started = 1;
    @(negedge clk);
    chk("rst_valid", {19'h0, out_valid}, 20'h0);
    chk("rst_ready", {19'h0, in_ready}, 20'h1);
    chk("rst_sticky", {16'h0, sticky_flags}, 20'h0);
    @(posedge clk);
    #1 out_ready = 1;
    norm(0, 7'd15, 10'h200, 1);
    peek("normal", {16'h3E00, 4'b0001}, 4'b0001);
    norm(1, 7'd31, 10'h155, 0);
    peek("overflow", {16'hFC00, 4'b0101}, 4'b0101);
    norm(0, 7'h7E, 10'h3FF, 1);
    peek("underflow", {16'h0000, 4'b0011}, 4'b0111);
    send(0, 7'd15, 10'h0, 0, 0, 1, 0, 1, 0);
    peek("invalid_inf", {16'h7E00, 4'b1000}, 4'b1111);
    send(1, 7'd40, 10'h0, 1, 0, 1, 0, 0, 0);
    peek("neg_inf", {16'hFC00, 4'b0000}, 4'b1111);
    send(1, 7'h70, 10'h0, 1, 0, 0, 1, 0, 0);
    peek("neg_zero", {16'h8000, 4'b0000}, 4'b1111);
    out_ready = 0;
    norm(0, 7'd16, 10'h001, 0);
    norm(0, 7'd20, 10'h3FF, 1);
    @(negedge clk);
    chk("full_ready", {19'h0, in_ready}, 20'h0);
    @(posedge clk);
    #1;
    fork
      norm(1, 7'd1, 10'h000, 0);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    idle(4, 0);
    send(0, 7'd40, 10'h0, 0, 0, 0, 0, 0, 1);
    peek("clr_accept", {16'h7C00, 4'b0101}, 4'b0101);
    idle(1, 1);
    @(negedge clk);
    chk("clr_alone", {16'h0, sticky_flags}, 20'h0);
    @(posedge clk);
    #1 out_ready = 0;
    norm(0, 7'd10, 10'h010, 1);
    norm(1, 7'd12, 10'h020, 1);
    do_reset();
    @(negedge clk);
    chk("mid_rst_valid", {19'h0, out_valid}, 20'h0);
    chk("mid_rst_ready", {19'h0, in_ready}, 20'h1);
    chk("mid_rst_sticky", {16'h0, sticky_flags}, 20'h0);
    @(posedge clk);
    #1 out_ready = 1;
    norm(0, 7'd15, 10'h200, 1);
    peek("post_rst", {16'h3E00, 4'b0001}, 4'b0001);
    @(negedge clk);
    chk("post_rst_alone", {19'h0, out_valid}, 20'h0);
    @(posedge clk);
    #1 rnd_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      logic [6:0] e;
      e = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 6)] : 7'($urandom);
      send($urandom_range(0, 1) != 0, e, 10'($urandom), $urandom_range(0, 1) != 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) idle(1, $urandom_range(0, 7) == 0);
    end
    rnd_rdy = 0;
    out_ready = 1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1, 0);
    chk("drain", 20'(sb.size()), 20'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
